// File: rtl/narrow_mem_bridge.sv
// Lane-serial bridge from N word-wide core memory ports to a narrow pin interface.
// Requests are round-robin arbitrated and read tags are queued so responses return to the issuing port.
module narrow_mem_bridge #(
  parameter int NumPorts       = 2,
  parameter int DataWidth      = 32,
  parameter int LaneWidth      = 4,
  parameter int AddrWidth      = 8,
  parameter int MaxOutstanding = 2
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NumPorts-1:0]               req_valid_i,
  output logic [NumPorts-1:0]               req_ready_o,
  input  logic [NumPorts*32-1:0]            req_addr_i,
  input  logic [NumPorts-1:0]               req_write_i,
  input  logic [NumPorts*DataWidth-1:0]     req_wdata_i,
  input  logic [NumPorts*DataWidth/8-1:0]   req_strb_i,
  output logic [NumPorts-1:0]               rsp_valid_o,
  input  logic [NumPorts-1:0]               rsp_ready_i,
  output logic [DataWidth-1:0]              rsp_rdata_o,
  output logic                              pin_req_valid_o,
  input  logic                              pin_req_ready_i,
  output logic [LaneWidth-1:0]              pin_req_data_o,
  output logic                              pin_req_strb_o,
  output logic                              pin_req_write_o,
  output logic [AddrWidth-1:0]              pin_req_addr_o,
  input  logic                              pin_rsp_valid_i,
  output logic                              pin_rsp_ready_o,
  input  logic [LaneWidth-1:0]              pin_rsp_data_i,
  input  logic                              pin_rsp_last_i,
  output logic [$clog2(MaxOutstanding+1)-1:0] outstanding_o,
  output logic                              rsp_unexpected_o
);

  localparam int Beats     = DataWidth / LaneWidth;
  localparam int StrbWidth = DataWidth / 8;
  localparam int AddrLsb   = $clog2(StrbWidth);
  localparam int PortW     = (NumPorts > 1) ? $clog2(NumPorts) : 1;
  localparam int BeatW     = (Beats > 1) ? $clog2(Beats) : 1;
  localparam int PtrW      = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam int CntW      = $clog2(MaxOutstanding + 1);

  localparam logic [0:0] ReqIdle    = 1'b0;
  localparam logic [0:0] ReqIssue   = 1'b1;
  localparam logic [0:0] RspCollect = 1'b0;
  localparam logic [0:0] RspHold    = 1'b1;

  logic [31:0]           addr_arr  [NumPorts];
  logic [DataWidth-1:0]  wdata_arr [NumPorts];
  logic [StrbWidth-1:0]  strb_arr  [NumPorts];

  genvar g;
  for (g = 0; g < NumPorts; g++) begin : g_unpack
    assign addr_arr[g]  = req_addr_i[32*g +: 32];
    assign wdata_arr[g] = req_wdata_i[DataWidth*g +: DataWidth];
    assign strb_arr[g]  = req_strb_i[StrbWidth*g +: StrbWidth];
  end

  logic [0:0]           req_state_q;
  logic [PortW-1:0]     rr_q;
  logic [AddrWidth-1:0] addr_q;
  logic                 write_q;
  logic [DataWidth-1:0] data_sh_q;
  logic [Beats-1:0]     lstrb_sh_q;
  logic [BeatW-1:0]     beat_q;
  logic                 valid_q;

  logic [CntW-1:0]      count_q;
  logic [PtrW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [PortW-1:0]     tag_mem [MaxOutstanding];
  logic [PortW-1:0]     head;

  logic [0:0]           rsp_state_q;
  logic                 rsp_rdy_q;
  logic [DataWidth-1:0] acc_q;
  logic                 unexpected_q;

  logic                 fifo_full;
  logic [NumPorts-1:0]  eligible;
  logic                 found;
  logic [PortW-1:0]     winner;
  logic [PortW:0]       cand;
  logic                 grant;
  logic                 sel_write;
  logic [StrbWidth-1:0] sel_strb;
  logic [Beats-1:0]     lane_strb;
  logic                 push, pop;
  logic                 last_beat;
  logic                 rsp_take;
  logic [DataWidth-1:0] acc_next;

  // Reads that would overflow the tag FIFO drop out of arbitration; writes never do.
  assign fifo_full = (count_q == CntW'(MaxOutstanding));
  assign eligible  = req_valid_i & (req_write_i | {NumPorts{~fifo_full}});

  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int k = 0; k < NumPorts; k++) begin
      cand = {1'b0, rr_q} + (PortW+1)'(k);
      if (cand >= (PortW+1)'(NumPorts)) cand = cand - (PortW+1)'(NumPorts);
      if (!found && eligible[cand[PortW-1:0]]) begin
        found  = 1'b1;
        winner = cand[PortW-1:0];
      end
    end
  end

  assign grant       = found & (req_state_q == ReqIdle);
  assign req_ready_o = grant ? (NumPorts'(1) << winner) : '0;
  assign sel_write   = req_write_i[winner];
  assign sel_strb    = strb_arr[winner];
  assign push        = grant & ~sel_write;

  for (g = 0; g < Beats; g++) begin : g_lane_strb
    assign lane_strb[g] = sel_strb[(g*LaneWidth)/8];
  end

  assign last_beat = ~write_q | (beat_q == BeatW'(Beats-1));

  // Data and per-beat strobes are pre-shifted so the current lane always sits at bit 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_state_q <= ReqIdle;
      rr_q        <= '0;
      addr_q      <= '0;
      write_q     <= 1'b0;
      data_sh_q   <= '0;
      lstrb_sh_q  <= '0;
      beat_q      <= '0;
      valid_q     <= 1'b0;
    end else if (req_state_q == ReqIdle) begin
      if (grant) begin
        req_state_q <= ReqIssue;
        rr_q        <= (winner == PortW'(NumPorts-1)) ? '0 : winner + 1'b1;
        addr_q      <= addr_arr[winner][AddrLsb +: AddrWidth];
        write_q     <= sel_write;
        data_sh_q   <= sel_write ? wdata_arr[winner] : '0;
        lstrb_sh_q  <= sel_write ? lane_strb : '0;
        beat_q      <= '0;
        valid_q     <= 1'b1;
      end
    end else if (valid_q && pin_req_ready_i) begin
      if (last_beat) begin
        req_state_q <= ReqIdle;
        addr_q      <= '0;
        write_q     <= 1'b0;
        data_sh_q   <= '0;
        lstrb_sh_q  <= '0;
        beat_q      <= '0;
        valid_q     <= 1'b0;
      end else begin
        beat_q      <= beat_q + 1'b1;
        data_sh_q   <= data_sh_q >> LaneWidth;
        lstrb_sh_q  <= lstrb_sh_q >> 1;
      end
    end
  end

  assign pin_req_valid_o = valid_q;
  assign pin_req_data_o  = data_sh_q[LaneWidth-1:0];
  assign pin_req_strb_o  = lstrb_sh_q[0];
  assign pin_req_write_o = write_q;
  assign pin_req_addr_o  = addr_q;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(MaxOutstanding-1)) ? '0 : p + 1'b1;
  endfunction

  assign head = tag_mem[rd_ptr_q];
  assign pop  = (rsp_state_q == RspHold) & rsp_ready_i[head];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < MaxOutstanding; i++) tag_mem[i] <= '0;
    end else begin
      if (push) begin
        tag_mem[wr_ptr_q] <= winner;
        wr_ptr_q          <= ptr_inc(wr_ptr_q);
      end
      if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (pop && !push) count_q <= count_q - 1'b1;
    end
  end

  assign outstanding_o = count_q;

  // First beat ends up most significant; a last beat with nothing outstanding is dropped and flagged.
  assign rsp_take = pin_rsp_valid_i & rsp_rdy_q;
  assign acc_next = (acc_q << LaneWidth) | DataWidth'(pin_rsp_data_i);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_state_q  <= RspCollect;
      rsp_rdy_q    <= 1'b0;
      acc_q        <= '0;
      unexpected_q <= 1'b0;
    end else if (rsp_state_q == RspCollect) begin
      rsp_rdy_q <= 1'b1;
      if (rsp_take) begin
        if (pin_rsp_last_i) begin
          if (count_q == '0) begin
            unexpected_q <= 1'b1;
            acc_q        <= '0;
          end else begin
            rsp_state_q <= RspHold;
            rsp_rdy_q   <= 1'b0;
            acc_q       <= acc_next;
          end
        end else begin
          acc_q <= acc_next;
        end
      end
    end else if (pop) begin
      rsp_state_q <= RspCollect;
      rsp_rdy_q   <= 1'b1;
      acc_q       <= '0;
    end
  end

  assign pin_rsp_ready_o  = rsp_rdy_q;
  assign rsp_valid_o      = (rsp_state_q == RspHold) ? (NumPorts'(1) << head) : '0;
  assign rsp_rdata_o      = (rsp_state_q == RspHold) ? acc_q : '0;
  assign rsp_unexpected_o = unexpected_q;

endmodule

// File: tb/tb_narrow_mem_bridge.sv
// Directed self-checking bench for narrow_mem_bridge at default parameters.
// Expected pin beats and response words are hand-derived constants.
module tb_narrow_mem_bridge;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req_valid_i, req_ready_o, req_write_i;
  logic [63:0] req_addr_i, req_wdata_i;
  logic [7:0]  req_strb_i;
  logic [1:0]  rsp_valid_o, rsp_ready_i;
  logic [31:0] rsp_rdata_o;
  logic        pin_req_valid_o, pin_req_ready_i;
  logic [3:0]  pin_req_data_o;
  logic        pin_req_strb_o, pin_req_write_o;
  logic [7:0]  pin_req_addr_o;
  logic        pin_rsp_valid_i, pin_rsp_ready_o;
  logic [3:0]  pin_rsp_data_i;
  logic        pin_rsp_last_i;
  logic [1:0]  outstanding_o;
  logic        rsp_unexpected_o;

  int errors = 0;
  int checks = 0;

  narrow_mem_bridge dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .req_valid_i      (req_valid_i),
    .req_ready_o      (req_ready_o),
    .req_addr_i       (req_addr_i),
    .req_write_i      (req_write_i),
    .req_wdata_i      (req_wdata_i),
    .req_strb_i       (req_strb_i),
    .rsp_valid_o      (rsp_valid_o),
    .rsp_ready_i      (rsp_ready_i),
    .rsp_rdata_o      (rsp_rdata_o),
    .pin_req_valid_o  (pin_req_valid_o),
    .pin_req_ready_i  (pin_req_ready_i),
    .pin_req_data_o   (pin_req_data_o),
    .pin_req_strb_o   (pin_req_strb_o),
    .pin_req_write_o  (pin_req_write_o),
    .pin_req_addr_o   (pin_req_addr_o),
    .pin_rsp_valid_i  (pin_rsp_valid_i),
    .pin_rsp_ready_o  (pin_rsp_ready_o),
    .pin_rsp_data_i   (pin_rsp_data_i),
    .pin_rsp_last_i   (pin_rsp_last_i),
    .outstanding_o    (outstanding_o),
    .rsp_unexpected_o (rsp_unexpected_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int port, input logic valid, input logic write,
                               input logic [31:0] addr, input logic [31:0] data,
                               input logic [3:0] strb);
    if (port == 0) begin
      req_valid_i[0]     = valid;
      req_write_i[0]     = write;
      req_addr_i[31:0]   = addr;
      req_wdata_i[31:0]  = data;
      req_strb_i[3:0]    = strb;
    end else begin
      req_valid_i[1]     = valid;
      req_write_i[1]     = write;
      req_addr_i[63:32]  = addr;
      req_wdata_i[63:32] = data;
      req_strb_i[7:4]    = strb;
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_req_ready"},  64'(req_ready_o), 64'd0);
    checkOutput({tag, "_rsp_valid"},  64'(rsp_valid_o), 64'd0);
    checkOutput({tag, "_rsp_rdata"},  64'(rsp_rdata_o), 64'd0);
    checkOutput({tag, "_pin_valid"},  64'(pin_req_valid_o), 64'd0);
    checkOutput({tag, "_pin_data"},   64'(pin_req_data_o), 64'd0);
    checkOutput({tag, "_pin_strb"},   64'(pin_req_strb_o), 64'd0);
    checkOutput({tag, "_pin_write"},  64'(pin_req_write_o), 64'd0);
    checkOutput({tag, "_pin_addr"},   64'(pin_req_addr_o), 64'd0);
    checkOutput({tag, "_pin_rsprdy"}, 64'(pin_rsp_ready_o), 64'd0);
    checkOutput({tag, "_outst"},      64'(outstanding_o), 64'd0);
    checkOutput({tag, "_unexp"},      64'(rsp_unexpected_o), 64'd0);
  endtask

  task automatic applyReset();
    rst_n           = 1'b0;
    req_valid_i     = '0;
    req_write_i     = '0;
    req_addr_i      = '0;
    req_wdata_i     = '0;
    req_strb_i      = '0;
    rsp_ready_i     = '0;
    pin_req_ready_i = 1'b1;
    pin_rsp_valid_i = 1'b0;
    pin_rsp_data_i  = '0;
    pin_rsp_last_i  = 1'b0;
    #1;
    checkResetOutputs("reset");
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Issues one write and follows its beats; abort_beat >= 0 asserts reset just before that beat.
  task automatic driveWrite(input int port, input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input bit stall, input int abort_beat);
    logic [31:0] sh;
    logic [3:0]  sb;
    logic [1:0]  oh;
    logic [7:0]  exp_addr;
    int k;
    int cyc;
    oh       = 2'b01 << port;
    exp_addr = addr[9:2];
    applyStimulus(port, 1'b1, 1'b1, addr, data, strb);
    #1;
    checkOutput("wr_req_ready", 64'(req_ready_o), 64'(oh));
    tick();
    applyStimulus(port, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    k   = 0;
    cyc = 0;
    while (k < 8 && cyc < 200) begin
      if (k == abort_beat) begin
        rst_n = 1'b0;
        #1;
        checkResetOutputs("abort");
        pin_req_ready_i = 1'b1;
        return;
      end
      pin_req_ready_i = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      checkOutput("wr_pin_valid", 64'(pin_req_valid_o), 64'd1);
      checkOutput("wr_pin_write", 64'(pin_req_write_o), 64'd1);
      checkOutput("wr_pin_addr",  64'(pin_req_addr_o), 64'(exp_addr));
      checkOutput("wr_busy_ready", 64'(req_ready_o), 64'd0);
      if (pin_req_ready_i) begin
        sh = data >> (4 * k);
        sb = strb >> (k / 2);
        checkOutput("wr_beat_data", 64'(pin_req_data_o), 64'(sh[3:0]));
        checkOutput("wr_beat_strb", 64'(pin_req_strb_o), 64'(sb[0]));
        k++;
      end
      tick();
      cyc++;
    end
    checkOutput("wr_beat_count", 64'(k), 64'd8);
    pin_req_ready_i = 1'b1;
    #1;
    checkOutput("wr_done_valid", 64'(pin_req_valid_o), 64'd0);
  endtask

  task automatic driveRead(input int port, input logic [31:0] addr, input logic [7:0] exp_addr);
    logic [1:0] oh;
    oh = 2'b01 << port;
    pin_req_ready_i = 1'b1;
    applyStimulus(port, 1'b1, 1'b0, addr, 32'h0, 4'h0);
    #1;
    checkOutput("rd_req_ready", 64'(req_ready_o), 64'(oh));
    tick();
    applyStimulus(port, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    #1;
    checkOutput("rd_pin_valid", 64'(pin_req_valid_o), 64'd1);
    checkOutput("rd_pin_write", 64'(pin_req_write_o), 64'd0);
    checkOutput("rd_pin_addr",  64'(pin_req_addr_o), 64'(exp_addr));
    checkOutput("rd_pin_data",  64'(pin_req_data_o), 64'd0);
    checkOutput("rd_pin_strb",  64'(pin_req_strb_o), 64'd0);
    tick();
    checkOutput("rd_done_valid", 64'(pin_req_valid_o), 64'd0);
  endtask

  task automatic sendRsp(input logic [31:0] data, input int nbeats);
    logic [31:0] sh;
    for (int k = 0; k < nbeats; k++) begin
      sh = data >> (4 * (nbeats - 1 - k));
      pin_rsp_valid_i = 1'b1;
      pin_rsp_data_i  = sh[3:0];
      pin_rsp_last_i  = (k == nbeats - 1);
      #1;
      checkOutput("rsp_beat_ready", 64'(pin_rsp_ready_o), 64'd1);
      tick();
    end
    pin_rsp_valid_i = 1'b0;
    pin_rsp_last_i  = 1'b0;
    pin_rsp_data_i  = '0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    applyReset();

    $display("[TB] write from port 1");
    driveWrite(1, 32'h44, 32'hDEADBEEF, 4'b0011, 1'b0, -1);
    checkOutput("t1_no_rsp", 64'(rsp_valid_o), 64'd0);

    $display("[TB] read from port 0");
    driveRead(0, 32'h10, 8'h04);
    checkOutput("t2_outst_issued", 64'(outstanding_o), 64'd1);
    sendRsp(32'h12345678, 8);
    checkOutput("t2_rsp_valid", 64'(rsp_valid_o), 64'h1);
    checkOutput("t2_rsp_rdata", 64'(rsp_rdata_o), 64'h12345678);
    checkOutput("t2_pin_rsp_hold", 64'(pin_rsp_ready_o), 64'd0);
    tick();
    checkOutput("t2_rsp_held", 64'(rsp_valid_o), 64'h1);
    rsp_ready_i = 2'b01;
    tick();
    rsp_ready_i = 2'b00;
    checkOutput("t2_rsp_popped", 64'(rsp_valid_o), 64'd0);
    checkOutput("t2_outst_zero", 64'(outstanding_o), 64'd0);
    checkOutput("t2_pin_rsp_rdy", 64'(pin_rsp_ready_o), 64'd1);

    $display("[TB] simultaneous reads from reset");
    applyReset();
    applyStimulus(0, 1'b1, 1'b0, 32'h20, 32'h0, 4'h0);
    applyStimulus(1, 1'b1, 1'b0, 32'h30, 32'h0, 4'h0);
    #1;
    checkOutput("t3_grant_p0", 64'(req_ready_o), 64'h1);
    tick();
    applyStimulus(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    #1;
    checkOutput("t3_issue_busy", 64'(req_ready_o), 64'd0);
    checkOutput("t3_p0_addr", 64'(pin_req_addr_o), 64'h08);
    tick();
    checkOutput("t3_grant_p1", 64'(req_ready_o), 64'h2);
    checkOutput("t3_outst_1", 64'(outstanding_o), 64'd1);
    tick();
    applyStimulus(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    #1;
    checkOutput("t3_p1_addr", 64'(pin_req_addr_o), 64'h0C);
    checkOutput("t3_outst_2", 64'(outstanding_o), 64'd2);
    tick();
    checkOutput("t3_idle", 64'(pin_req_valid_o), 64'd0);
    sendRsp(32'hAAAAAAAA, 8);
    checkOutput("t3_rsp0_valid", 64'(rsp_valid_o), 64'h1);
    checkOutput("t3_rsp0_rdata", 64'(rsp_rdata_o), 64'hAAAAAAAA);
    rsp_ready_i = 2'b01;
    tick();
    rsp_ready_i = 2'b00;
    checkOutput("t3_outst_after_pop", 64'(outstanding_o), 64'd1);
    sendRsp(32'h55555555, 8);
    checkOutput("t3_rsp1_valid", 64'(rsp_valid_o), 64'h2);
    checkOutput("t3_rsp1_rdata", 64'(rsp_rdata_o), 64'h55555555);
    rsp_ready_i = 2'b10;
    tick();
    rsp_ready_i = 2'b00;
    checkOutput("t3_outst_end", 64'(outstanding_o), 64'd0);

    $display("[TB] write with random pin stalls");
    driveWrite(0, 32'h1C, 32'h13579BDF, 4'b1010, 1'b1, -1);

    $display("[TB] outstanding limit");
    applyReset();
    driveRead(0, 32'h00, 8'h00);
    driveRead(1, 32'h04, 8'h01);
    checkOutput("t5_outst_full", 64'(outstanding_o), 64'd2);
    applyStimulus(0, 1'b1, 1'b0, 32'h08, 32'h0, 4'h0);
    #1;
    checkOutput("t5_read_masked", 64'(req_ready_o), 64'd0);
    tick();
    checkOutput("t5_read_masked2", 64'(req_ready_o), 64'd0);
    driveWrite(1, 32'h40, 32'h0BADF00D, 4'hF, 1'b0, -1);
    checkOutput("t5_read_masked3", 64'(req_ready_o), 64'd0);
    sendRsp(32'h11111111, 8);
    checkOutput("t5_rsp_valid", 64'(rsp_valid_o), 64'h1);
    checkOutput("t5_rsp_rdata", 64'(rsp_rdata_o), 64'h11111111);
    rsp_ready_i = 2'b01;
    tick();
    rsp_ready_i = 2'b00;
    checkOutput("t5_outst_pop", 64'(outstanding_o), 64'd1);
    checkOutput("t5_read_unmasked", 64'(req_ready_o), 64'h1);
    tick();
    applyStimulus(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    #1;
    checkOutput("t5_third_addr", 64'(pin_req_addr_o), 64'h02);
    checkOutput("t5_outst_refill", 64'(outstanding_o), 64'd2);
    tick();

    $display("[TB] unexpected response and mid-write reset");
    applyReset();
    sendRsp(32'h3, 1);
    checkOutput("t6_unexp", 64'(rsp_unexpected_o), 64'd1);
    checkOutput("t6_no_rsp", 64'(rsp_valid_o), 64'd0);
    checkOutput("t6_collect", 64'(pin_rsp_ready_o), 64'd1);
    tick();
    checkOutput("t6_unexp_sticky", 64'(rsp_unexpected_o), 64'd1);
    driveWrite(0, 32'h80, 32'hCAFEF00D, 4'hF, 1'b0, 3);
    tick();
    rst_n = 1'b1;
    tick();
    driveWrite(0, 32'h80, 32'hCAFEF00D, 4'hF, 1'b0, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/narrow_mem_bridge.md
# narrow_mem_bridge

Parametrised bridge between N word-wide core memory ports (instruction fetch, LSU, …) and a narrow lane-serial pin interface to the eFPGA-side memory converter. It replaces the fixed two-port/32-bit/4-bit serializer with configurable port count, data width, lane width and address width. It adds a read-tag FIFO so up to MaxOutstanding reads can be in flight and each response is routed back to the port that issued it. Sits between the core's memory ports and the chip's dedicated/bidirectional I/O.

## Interface
- NumPorts, 2, number of requesting ports (≥1); port 0 is instruction fetch by convention
- DataWidth, 32, core word width; multiple of 8 and of LaneWidth
- LaneWidth, 4, pin data lane width; one of 1, 2, 4, 8
- AddrWidth, 8, word-address bits driven to pins
- MaxOutstanding, 2, read-tag FIFO depth (≥1)
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- req_valid_i / req_ready_o  in/out  NumPorts  per-port request handshake
- req_addr_i  in  NumPorts*32  byte addresses; port i at [32i+:32]
- req_write_i  in  NumPorts  1 = write
- req_wdata_i  in  NumPorts*DataWidth  write data
- req_strb_i  in  NumPorts*DataWidth/8  byte strobes
- rsp_valid_o / rsp_ready_i  out/in  NumPorts  per-port read-response handshake
- rsp_rdata_o  out  DataWidth  response data, shared by all ports
- pin_req_valid_o / pin_req_ready_i  out/in  1  pin request beat handshake
- pin_req_data_o  out  LaneWidth  request data lane
- pin_req_strb_o  out  1  strobe of the byte holding the current lane
- pin_req_write_o  out  1  write flag, held for the whole transaction
- pin_req_addr_o  out  AddrWidth  word address = req_addr[AddrLsb +: AddrWidth], AddrLsb = log2(DataWidth/8)
- pin_rsp_valid_i / pin_rsp_ready_o  in/out  1  pin response beat handshake
- pin_rsp_data_i  in  LaneWidth  response lane
- pin_rsp_last_i  in  1  marks final response beat
- outstanding_o  out  $clog2(MaxOutstanding+1)  reads issued and not yet delivered
- rsp_unexpected_o  out  1  sticky: response arrived with no outstanding read

## Operation
- Reset values: all *_valid_o, *_ready_o, pin_req_* outputs, rsp_rdata_o, outstanding_o and rsp_unexpected_o are 0; RR pointer 0; both FSMs in their first state.
- Request FSM: IDLE, ISSUE.
  - IDLE: round-robin arbiter over req_valid_i, starting at the RR pointer. When a read would overflow the FIFO (outstanding == MaxOutstanding), that read is masked from arbitration; writes still compete. req_ready_o is 1 only for the winner.
  - On accept: capture addr, write flag, data and strobes; RR pointer moves to winner+1 mod NumPorts. A read pushes the winner index into the tag FIFO and goes to ISSUE.
  - ISSUE, write: Beats = DataWidth/LaneWidth beats, LSB lane first. Beat k drives data[k*LaneWidth +: LaneWidth] and strb[(k*LaneWidth)/8].
  - ISSUE, read: one beat with data 0, strb 0.
  - pin_req_write_o and pin_req_addr_o are held constant throughout ISSUE. A beat advances only on pin_req_valid_o & pin_req_ready_i.
  - After the final beat handshake, go to IDLE. Writes are posted and produce no response.
- Response FSM: COLLECT, HOLD.
  - COLLECT: pin_rsp_ready_o = 1. Each accepted beat updates acc = (acc << LaneWidth) | pin_rsp_data_i, truncated to DataWidth, so the first beat becomes most significant. A beat carrying pin_rsp_last_i moves to HOLD.
  - HOLD: pin_rsp_ready_o = 0; rsp_rdata_o = acc; rsp_valid_o asserted only at the port given by the FIFO head. On rsp_ready_i at that port: pop the FIFO, clear acc, return to COLLECT.
  - Short bursts (last before Beats beats) deliver the accumulated value zero-extended. Long bursts keep the low DataWidth bits.
- Last beat with FIFO empty: data discarded, rsp_unexpected_o set (cleared only by reset), FSM stays in COLLECT.
- outstanding_o increments on read accept and decrements on pop. Accept and pop in the same cycle leave it unchanged. Push and pop may occur in the same cycle.

## Timing
- Request accepted at edge N: pin_req_valid_o high from cycle N+1. It is registered, with no combinational path from req_* to pin_*.
- Write occupancy with pin_req_ready_i constantly high: Beats+1 cycles (the IDLE cycle is an accept cycle). Read occupancy: 2 cycles.
- Last response beat accepted at edge M: rsp_valid_o high in cycle M+1. pin_rsp_ready_o is low from M+1 until the cycle after the pop.
- Responses return in issue order; a HOLD on port i blocks all later responses.
- rst_n asserted mid-transaction: everything returns to reset values immediately. In-flight beats and tags are dropped.

## Test plan
- Defaults; port1 writes addr 0x44, data 0xDEADBEEF, strb 4'b0011 -> 8 beats, data F,E,E,B,D,A,E,D, strb 1,1,1,1,0,0,0,0, addr 0x11, write 1; no rsp_valid.
- Port0 reads addr 0x10 -> one beat, addr 0x04, write 0. Response beats 1..8 with last on 8 -> rsp_valid_o = 2'b01, rsp_rdata_o 0x12345678 one cycle after the last beat.
- Both ports request reads in the same cycle from reset -> port0 issued first, then port1. Responses 0xAAAAAAAA then 0x55555555 are delivered to port0 then port1.
- pin_req_ready_i toggled randomly during a write -> no beat is lost or duplicated; addr and write stay stable; occupancy grows by exactly the number of stall cycles.
- MaxOutstanding=2, three reads with no responses -> outstanding_o = 2 and the third req_ready_o stays 0 until the first pop, then the third read is accepted; a pending write on another port is still accepted meanwhile.
- Response with last while outstanding_o = 0 -> rsp_unexpected_o = 1, no rsp_valid_o. Then rst_n low during a write beat 3 -> all outputs 0 within the reset, next write restarts at beat 0.
